// File: rtl/spi_slave_fifo_pkg.sv
// Shared types and constants for the SPI responder.
// Optional macro SPI_SLV_LSB_FIRST_EN (used in spi_slave_fifo.sv) selects LSB-first framing.
package spi_pkg;

    localparam int SPI_DATA_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_slave_fifo_if.sv
// SPI wires plus the local TX/RX byte handshakes of the responder.
interface spi_slave_fifo_if #(parameter int CNT_W = 3);

    logic             sck;
    logic             ss;
    logic             mosi;
    logic             miso;
    logic             miso_oe;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [CNT_W-1:0] rx_count;

    modport slave (
        input  sck, ss, mosi, tx_data, tx_valid, rx_ready,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, rx_count
    );

    modport master (
        output sck, ss, mosi, tx_data, tx_valid, rx_ready,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, rx_count
    );

endinterface

// File: rtl/spi_rx_fifo.sv
// Synchronous FIFO for received bytes; push on full and pop on empty are ignored.
module spi_rx_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_slave_fifo.sv
// SPI mode-0 responder oversampled in the clk domain, with RX FIFO and one-entry TX holding register.
// Define SPI_SLV_LSB_FIRST_EN for LSB-first framing on both mosi and miso.
module spi_slave_fifo
    import spi_pkg::*;
#(
    parameter int                    RX_DEPTH   = 4,
    parameter logic [SPI_DATA_W-1:0] DUMMY_BYTE = 8'hFF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr_err,
    output logic busy,
    output logic irq,
    output logic rx_overflow,
    output logic tx_underrun,
    output logic frame_err,
    spi_slave_fifo_if.slave bus
);

    localparam int CW = $clog2(RX_DEPTH) + 1;

    logic [SPI_SYNC_STAGES:0]   sck_s;
    logic [SPI_SYNC_STAGES:0]   ss_s;
    logic [SPI_SYNC_STAGES-1:0] mosi_s;
    logic sck_rise, sck_fall, ss_fall, ss_lvl, mosi_bit;

    spi_state_e state_q, state_d;
    logic [3:0]            bit_cnt;
    logic [SPI_DATA_W-1:0] tx_shift;
    logic [SPI_DATA_W-1:0] rx_shift;
    logic [SPI_DATA_W-1:0] hold_data;
    logic                  hold_full;
    logic do_load, do_sample, do_tx_shift, do_push, ferr_d, abort, tx_fire;

    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    assign sck_rise =  sck_s[SPI_SYNC_STAGES-1] && !sck_s[SPI_SYNC_STAGES];
    assign sck_fall = !sck_s[SPI_SYNC_STAGES-1] &&  sck_s[SPI_SYNC_STAGES];
    assign ss_fall  = !ss_s[SPI_SYNC_STAGES-1]  &&  ss_s[SPI_SYNC_STAGES];
    assign ss_lvl   =  ss_s[SPI_SYNC_STAGES-1];
    assign mosi_bit =  mosi_s[SPI_SYNC_STAGES-1];

    // Deselect (synced level) or disable both terminate an unfinished byte.
    assign abort   = ss_lvl || !en;
    assign tx_fire = bus.tx_valid && !hold_full;

    always_comb begin
        state_d     = state_q;
        do_load     = 1'b0;
        do_sample   = 1'b0;
        do_tx_shift = 1'b0;
        do_push     = 1'b0;
        ferr_d      = 1'b0;
        case (state_q)
            IDLE: if (en && ss_fall) state_d = LOAD;
            LOAD: begin
                do_load = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    if (sck_rise) begin
                        do_sample = 1'b1;
                        if (bit_cnt == 4'd7) state_d = DONE;
                    end
                    // The first falling edge belongs to the previous byte; bit 0/7 is already out.
                    if (sck_fall && bit_cnt != 4'd0) do_tx_shift = 1'b1;
                end
            end
            DONE: begin
                do_push = 1'b1;
                state_d = (en && !ss_lvl) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sck_s       <= '0;
            ss_s        <= '1;
            mosi_s      <= '0;
            state_q     <= IDLE;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            rx_overflow <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sck_s     <= {sck_s[SPI_SYNC_STAGES-1:0], bus.sck};
            ss_s      <= {ss_s[SPI_SYNC_STAGES-1:0], bus.ss};
            mosi_s    <= {mosi_s[SPI_SYNC_STAGES-2:0], bus.mosi};
            state_q   <= state_d;
            frame_err <= ferr_d;

            if (do_load) begin
                tx_shift <= hold_full ? hold_data : DUMMY_BYTE;
                bit_cnt  <= '0;
            end else if (do_tx_shift) begin
`ifdef SPI_SLV_LSB_FIRST_EN
                tx_shift <= tx_shift >> 1;
`else
                tx_shift <= tx_shift << 1;
`endif
            end

            if (do_sample) begin
`ifdef SPI_SLV_LSB_FIRST_EN
                rx_shift <= {mosi_bit, rx_shift[SPI_DATA_W-1:1]};
`else
                rx_shift <= {rx_shift[SPI_DATA_W-2:0], mosi_bit};
`endif
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (do_load && hold_full) begin
                hold_full <= 1'b0;
            end else if (tx_fire) begin
                hold_full <= 1'b1;
                hold_data <= bus.tx_data;
            end

            if (do_push && fifo_full) rx_overflow <= 1'b1;
            else if (clr_err)         rx_overflow <= 1'b0;

            if (do_load && !hold_full) tx_underrun <= 1'b1;
            else if (clr_err)          tx_underrun <= 1'b0;
        end
    end

    spi_rx_fifo #(.DEPTH(RX_DEPTH), .W(SPI_DATA_W)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .din   (rx_shift),
        .pop   (bus.rx_ready),
        .dout  (bus.rx_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.rx_count = fifo_count;
    assign bus.rx_valid = !fifo_empty;
    assign bus.tx_ready = !hold_full;
    assign bus.miso_oe  = (state_q != IDLE) && en;
`ifdef SPI_SLV_LSB_FIRST_EN
    assign bus.miso     = bus.miso_oe && tx_shift[0];
`else
    assign bus.miso     = bus.miso_oe && tx_shift[SPI_DATA_W-1];
`endif
    assign busy         = !ss_lvl && en;
    assign irq          = !fifo_empty && en;

endmodule
